// File: rtl/spectrum_peak_tracker.sv
// ---------------------------------------------------------------------------
// spectrum_peak_tracker
//
// Follows the strongest bin of a streamed FFT magnitude spectrum. It scans
// each frame for the maximum inside a configurable bin window. It then
// commits a new frequency control word once enough consecutive frames agree
// on roughly the same bin.
//
// Ports
//   sys_clk                single clock, rising edge
//   sys_rstn               synchronous reset, active-low
//   s_magni_valid          magnitude sample strobe
//   s_magni_addr           bin index of the sample
//   s_magni_data           unsigned bin magnitude
//   s_magni_last           final sample of a frame (qualified by valid)
//   cfg_bin_lo/hi          inclusive search window
//   cfg_threshold          minimum peak magnitude for a frame to count
//   s_sta_ram_trav         downstream busy; a commit waits while high
//   m_convert_config_data  committed frequency control word (bin * FCW_PER_BIN)
//   m_convert_config_step  |new bin - previous committed bin|, saturated at 127
//   m_peak_bin             committed bin
//   m_peak_valid           one-cycle pulse per commit
//   m_peak_lock            high while the tracker is locked
//   m_frame_drop           one-cycle pulse when a sample is discarded
// ---------------------------------------------------------------------------
module spectrum_peak_tracker #(
  parameter int          ADDR_W      = 9,
  parameter int          MAG_W       = 16,
  parameter logic [31:0] FCW_PER_BIN = 32'd8589934,
  parameter int          LOCK_FRAMES = 3,
  parameter int          LOCK_TOL    = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              s_magni_valid,
  input  logic [ADDR_W-1:0] s_magni_addr,
  input  logic [MAG_W-1:0]  s_magni_data,
  input  logic              s_magni_last,
  input  logic [ADDR_W-1:0] cfg_bin_lo,
  input  logic [ADDR_W-1:0] cfg_bin_hi,
  input  logic [MAG_W-1:0]  cfg_threshold,
  input  logic              s_sta_ram_trav,
  output logic [31:0]       m_convert_config_data,
  output logic [6:0]        m_convert_config_step,
  output logic [ADDR_W-1:0] m_peak_bin,
  output logic              m_peak_valid,
  output logic              m_peak_lock,
  output logic              m_frame_drop
);

  localparam logic [3:0]        LOCK_CNT = 4'(LOCK_FRAMES);
  localparam logic [ADDR_W-1:0] TOL      = ADDR_W'(LOCK_TOL);

  typedef enum logic [1:0] {SCAN, EVAL, HOLD} state_t;

  state_t state, state_nxt;

  logic [MAG_W-1:0]  run_max;
  logic [ADDR_W-1:0] cand_bin;
  logic              cand_seen;
  logic [ADDR_W-1:0] prev_cand;
  logic [3:0]        agree_cnt;
  logic [ADDR_W-1:0] pending_bin;

  logic              in_window;
  logic              take_sample;
  logic              frame_end;
  logic              frame_ok;
  logic              agree;
  logic [3:0]        cnt_next;
  logic              reach_lock;
  logic              do_commit;
  logic [ADDR_W-1:0] commit_bin;
  logic [31:0]       step_wide;

  function automatic logic [ADDR_W-1:0] abs_diff(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // An inverted window (lo > hi) can never match, so such frames are
  // always invalid. The first in-window sample is always taken so that a
  // magnitude of zero is still a legal maximum. After that, only a strictly
  // larger value replaces it, which keeps the earliest of equal peaks.
  assign in_window   = (s_magni_addr >= cfg_bin_lo) && (s_magni_addr <= cfg_bin_hi);
  assign take_sample = (state == SCAN) && s_magni_valid && in_window &&
                       (!cand_seen || (s_magni_data > run_max));
  assign frame_end   = (state == SCAN) && s_magni_valid && s_magni_last;

  // A frame only counts toward lock if it had a real in-window peak above
  // threshold. Agreement needs a previous valid frame (count non-zero),
  // so the first frame after a loss always restarts the count at 1.
  assign frame_ok   = cand_seen && (run_max >= cfg_threshold);
  assign agree      = (abs_diff(cand_bin, prev_cand) <= TOL) && (agree_cnt != 4'd0);
  assign cnt_next   = !agree ? 4'd1 :
                      (agree_cnt >= LOCK_CNT) ? LOCK_CNT : agree_cnt + 4'd1;
  assign reach_lock = frame_ok && (cnt_next == LOCK_CNT);

  // State register for the scan / evaluate / hold sequence.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state <= SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and commit decision. EVAL lasts exactly one cycle.
  // A commit that meets a busy downstream is parked in HOLD, and HOLD
  // releases the pending bin on the first idle cycle.
  always_comb begin
    state_nxt  = state;
    do_commit  = 1'b0;
    commit_bin = cand_bin;
    case (state)
      SCAN: begin
        if (frame_end) state_nxt = EVAL;
      end
      EVAL: begin
        if (reach_lock && s_sta_ram_trav) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = SCAN;
          do_commit = reach_lock;
        end
      end
      HOLD: begin
        commit_bin = pending_bin;
        if (!s_sta_ram_trav) begin
          state_nxt = SCAN;
          do_commit = 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  assign step_wide = 32'(abs_diff(commit_bin, m_peak_bin));

  // Running-max search. All search state is wiped on every return to SCAN.
  // Because of that, the tail of a frame that was cut off by a drop is
  // simply treated as a fresh frame.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      run_max   <= '0;
      cand_bin  <= '0;
      cand_seen <= 1'b0;
    end else if ((state != SCAN) && (state_nxt == SCAN)) begin
      run_max   <= '0;
      cand_bin  <= '0;
      cand_seen <= 1'b0;
    end else if (take_sample) begin
      run_max   <= s_magni_data;
      cand_bin  <= s_magni_addr;
      cand_seen <= 1'b1;
    end
  end

  // Frame-to-frame agreement tracking, updated once per frame in EVAL.
  // An invalid frame zeroes the count but leaves prev_cand untouched.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      prev_cand   <= '0;
      agree_cnt   <= '0;
      pending_bin <= '0;
    end else if (state == EVAL) begin
      if (!frame_ok) begin
        agree_cnt <= 4'd0;
      end else begin
        agree_cnt <= cnt_next;
        prev_cand <= cand_bin;
      end
      if (reach_lock && s_sta_ram_trav) pending_bin <= cand_bin;
    end
  end

  // Output registers. A commit wins over a lock-loss on the same frame.
  // This matters only when LOCK_FRAMES is 1. Losing lock never clears the
  // committed word, step or bin.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      m_convert_config_data <= '0;
      m_convert_config_step <= '0;
      m_peak_bin            <= '0;
      m_peak_valid          <= 1'b0;
      m_peak_lock           <= 1'b0;
      m_frame_drop          <= 1'b0;
    end else begin
      m_peak_valid <= do_commit;
      m_frame_drop <= s_magni_valid && (state != SCAN);
      if (do_commit) begin
        m_convert_config_data <= 32'(commit_bin) * FCW_PER_BIN;
        m_convert_config_step <= (step_wide > 32'd127) ? 7'd127 : step_wide[6:0];
        m_peak_bin            <= commit_bin;
        m_peak_lock           <= 1'b1;
      end else if ((state == EVAL) && (!frame_ok || !agree)) begin
        m_peak_lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// ---------------------------------------------------------------------------
// tb_spectrum_peak_tracker
//
// Directed bench for spectrum_peak_tracker with default parameters.
// Each scenario task drives frames and compares outputs inline against
// hand-computed values. A snapshot packs {valid, lock, bin, step, data}
// so that one comparison covers a whole commit.
// ---------------------------------------------------------------------------
module tb_spectrum_peak_tracker;

  logic        sys_clk = 1'b0;
  logic        sys_rstn;
  logic        s_magni_valid;
  logic [8:0]  s_magni_addr;
  logic [15:0] s_magni_data;
  logic        s_magni_last;
  logic [8:0]  cfg_bin_lo;
  logic [8:0]  cfg_bin_hi;
  logic [15:0] cfg_threshold;
  logic        s_sta_ram_trav;
  logic [31:0] m_convert_config_data;
  logic [6:0]  m_convert_config_step;
  logic [8:0]  m_peak_bin;
  logic        m_peak_valid;
  logic        m_peak_lock;
  logic        m_frame_drop;

  int n_checks = 0;
  int n_fail   = 0;

  spectrum_peak_tracker dut (
    .sys_clk               (sys_clk),
    .sys_rstn              (sys_rstn),
    .s_magni_valid         (s_magni_valid),
    .s_magni_addr          (s_magni_addr),
    .s_magni_data          (s_magni_data),
    .s_magni_last          (s_magni_last),
    .cfg_bin_lo            (cfg_bin_lo),
    .cfg_bin_hi            (cfg_bin_hi),
    .cfg_threshold         (cfg_threshold),
    .s_sta_ram_trav        (s_sta_ram_trav),
    .m_convert_config_data (m_convert_config_data),
    .m_convert_config_step (m_convert_config_step),
    .m_peak_bin            (m_peak_bin),
    .m_peak_valid          (m_peak_valid),
    .m_peak_lock           (m_peak_lock),
    .m_frame_drop          (m_frame_drop)
  );

  always #5 sys_clk = ~sys_clk;

  // Safety net so that a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [49:0] snap();
    return {m_peak_valid, m_peak_lock, m_peak_bin, m_convert_config_step, m_convert_config_data};
  endfunction

  function automatic logic [49:0] pack(input logic v, input logic l, input logic [8:0] b,
                                       input logic [6:0] s, input logic [31:0] d);
    return {v, l, b, s, d};
  endfunction

  // One sample, held for one clock. The task returns on the next falling
  // edge with valid low, so back-to-back calls stream without gaps.
  task automatic apply_sample(input logic [8:0] addr, input logic [15:0] data, input logic last);
    s_magni_valid = 1'b1;
    s_magni_addr  = addr;
    s_magni_data  = data;
    s_magni_last  = last;
    @(negedge sys_clk);
    s_magni_valid = 1'b0;
    s_magni_last  = 1'b0;
  endtask

  // Four-sample frame. Bin 0 and bin 300 carry huge values outside the
  // usual 1..255 window, and a small in-window sample closes the frame.
  // The task returns on the falling edge after the last sample was taken,
  // which is while the DUT is in EVAL.
  task automatic apply_frame(input logic [8:0] peak_bin, input logic [15:0] peak_mag);
    apply_sample(9'd0, 16'd60000, 1'b0);
    apply_sample(peak_bin, peak_mag, 1'b0);
    apply_sample(9'd300, 16'd60000, 1'b0);
    apply_sample(9'd200, 16'd7, 1'b1);
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({snap(), m_frame_drop} !== 51'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {snap(), m_frame_drop});
    end
    sys_rstn = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_lock_acquire();
    for (int f = 1; f <= 3; f++) begin
      apply_frame(9'd25, 16'd1000);
      n_checks++;
      if (m_peak_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL acq_early_f%0d: valid got %b expected 0", f, m_peak_valid);
      end
      @(negedge sys_clk);
      if (f < 3) begin
        n_checks++;
        if (m_peak_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL acq_nocommit_f%0d: valid got %b expected 0", f, m_peak_valid);
        end
      end else begin
        n_checks++;
        if (snap() !== pack(1'b1, 1'b1, 9'd25, 7'd25, 32'd214748350)) begin
          n_fail++;
          $display("[TB] FAIL acq_commit: got %h expected %h", snap(),
                   pack(1'b1, 1'b1, 9'd25, 7'd25, 32'd214748350));
        end
      end
    end
    @(negedge sys_clk);
    n_checks++;
    if (m_peak_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL acq_pulse_width: valid got %b expected 0", m_peak_valid);
    end
  endtask

  task automatic test_track();
    apply_frame(9'd27, 16'd1000);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b1, 1'b1, 9'd27, 7'd2, 32'd231928218)) begin
      n_fail++;
      $display("[TB] FAIL track_27: got %h expected %h", snap(),
               pack(1'b1, 1'b1, 9'd27, 7'd2, 32'd231928218));
    end
    apply_frame(9'd31, 16'd1000);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b0, 1'b0, 9'd27, 7'd2, 32'd231928218)) begin
      n_fail++;
      $display("[TB] FAIL track_31_unlock: got %h expected %h", snap(),
               pack(1'b0, 1'b0, 9'd27, 7'd2, 32'd231928218));
    end
  endtask

  // The jump to 31 restarted the count at 1, so two more frames at 31
  // are needed to commit.
  task automatic test_relock();
    apply_frame(9'd31, 16'd1000);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b0, 1'b0, 9'd27, 7'd2, 32'd231928218)) begin
      n_fail++;
      $display("[TB] FAIL relock_count2: got %h expected %h", snap(),
               pack(1'b0, 1'b0, 9'd27, 7'd2, 32'd231928218));
    end
    apply_frame(9'd31, 16'd1000);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b1, 1'b1, 9'd31, 7'd4, 32'd266287954)) begin
      n_fail++;
      $display("[TB] FAIL relock_commit: got %h expected %h", snap(),
               pack(1'b1, 1'b1, 9'd31, 7'd4, 32'd266287954));
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    s_sta_ram_trav = 1'b1;
    apply_frame(9'd33, 16'd1000);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      pulses += int'(m_peak_valid);
      if (i == 2) begin
        s_magni_valid = 1'b1;
        s_magni_addr  = 9'd5;
        s_magni_data  = 16'd10;
      end
      if (i == 3) begin
        s_magni_valid = 1'b0;
        n_checks++;
        if (m_frame_drop !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL hold_drop: drop got %b expected 1", m_frame_drop);
        end
      end
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("[TB] FAIL hold_no_pulse: pulses got %0d expected 0", pulses);
    end
    s_sta_ram_trav = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b1, 1'b1, 9'd33, 7'd2, 32'd283467822)) begin
      n_fail++;
      $display("[TB] FAIL hold_release: got %h expected %h", snap(),
               pack(1'b1, 1'b1, 9'd33, 7'd2, 32'd283467822));
    end
    @(negedge sys_clk);
  endtask

  task automatic test_invalid();
    apply_frame(9'd40, 16'd50);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b0, 1'b0, 9'd33, 7'd2, 32'd283467822)) begin
      n_fail++;
      $display("[TB] FAIL inv_threshold: got %h expected %h", snap(),
               pack(1'b0, 1'b0, 9'd33, 7'd2, 32'd283467822));
    end
    cfg_bin_lo = 9'd200;
    cfg_bin_hi = 9'd100;
    apply_frame(9'd33, 16'd1000);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b0, 1'b0, 9'd33, 7'd2, 32'd283467822)) begin
      n_fail++;
      $display("[TB] FAIL inv_empty_window: got %h expected %h", snap(),
               pack(1'b0, 1'b0, 9'd33, 7'd2, 32'd283467822));
    end
    // The invalid frames zeroed the count, so one agreeing frame cannot commit.
    cfg_bin_lo = 9'd1;
    cfg_bin_hi = 9'd255;
    apply_frame(9'd33, 16'd1000);
    @(negedge sys_clk);
    n_checks++;
    if (m_peak_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL inv_count_cleared: valid got %b expected 0", m_peak_valid);
    end
  endtask

  task automatic test_tie_and_drop();
    for (int f = 1; f <= 3; f++) begin
      apply_sample(9'd10, 16'd500, 1'b0);
      apply_sample(9'd40, 16'd500, 1'b1);
      if (f == 1) begin
        s_magni_valid = 1'b1;
        s_magni_addr  = 9'd10;
        s_magni_data  = 16'd60000;
      end
      @(negedge sys_clk);
      s_magni_valid = 1'b0;
      if (f == 1) begin
        n_checks++;
        if (m_frame_drop !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL eval_drop: drop got %b expected 1", m_frame_drop);
        end
      end
    end
    n_checks++;
    if (snap() !== pack(1'b1, 1'b1, 9'd10, 7'd23, 32'd85899340)) begin
      n_fail++;
      $display("[TB] FAIL tie_first_wins: got %h expected %h", snap(),
               pack(1'b1, 1'b1, 9'd10, 7'd23, 32'd85899340));
    end
  endtask

  task automatic test_last_sample();
    apply_sample(9'd12, 16'd300, 1'b0);
    apply_sample(9'd11, 16'd800, 1'b1);
    @(negedge sys_clk);
    n_checks++;
    if (snap() !== pack(1'b1, 1'b1, 9'd11, 7'd1, 32'd94489274)) begin
      n_fail++;
      $display("[TB] FAIL last_sample_peak: got %h expected %h", snap(),
               pack(1'b1, 1'b1, 9'd11, 7'd1, 32'd94489274));
    end
  endtask

  task automatic test_reset_in_hold();
    int pulses = 0;
    s_sta_ram_trav = 1'b1;
    apply_frame(9'd11, 16'd1000);
    repeat (2) @(negedge sys_clk);
    sys_rstn = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if ({snap(), m_frame_drop} !== 51'd0) begin
      n_fail++;
      $display("[TB] FAIL hold_reset_outputs: got %h expected 0", {snap(), m_frame_drop});
    end
    sys_rstn       = 1'b1;
    s_sta_ram_trav = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      pulses += int'(m_peak_valid);
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("[TB] FAIL hold_reset_no_pulse: pulses got %0d expected 0", pulses);
    end
    for (int f = 1; f <= 3; f++) begin
      apply_frame(9'd25, 16'd1000);
      @(negedge sys_clk);
      n_checks++;
      if (f < 3 && m_peak_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL post_reset_early_f%0d: valid got %b expected 0", f, m_peak_valid);
      end else if (f == 3 && snap() !== pack(1'b1, 1'b1, 9'd25, 7'd25, 32'd214748350)) begin
        n_fail++;
        $display("[TB] FAIL post_reset_commit: got %h expected %h", snap(),
                 pack(1'b1, 1'b1, 9'd25, 7'd25, 32'd214748350));
      end
    end
  endtask

  initial begin
    sys_rstn       = 1'b0;
    s_magni_valid  = 1'b0;
    s_magni_addr   = '0;
    s_magni_data   = '0;
    s_magni_last   = 1'b0;
    cfg_bin_lo     = 9'd1;
    cfg_bin_hi     = 9'd255;
    cfg_threshold  = 16'd100;
    s_sta_ram_trav = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_lock_acquire();
    test_track();
    test_relock();
    test_hold();
    test_invalid();
    test_tie_and_drop();
    test_last_sample();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
